// File: rtl/alveo_hls4ml_sdiv_seq_30s_14s_16_pkg.sv
// Shared constants, state encoding and helpers for the 30s/14s -> 16s
// sequential signed divider.
package alveo_hls4ml_sdiv_seq_30s_14s_16_pkg;

  localparam int W_DIN0 = 30;
  localparam int W_DIN1 = 14;
  localparam int W_DOUT = 16;
  localparam int ITER   = 30;
  localparam int W_CNT  = 5;

  localparam logic [W_DOUT-1:0] QMAX = 16'h7FFF;
  localparam logic [W_DOUT-1:0] QMIN = 16'h8000;
  localparam logic [W_CNT-1:0]  CNT_LAST = W_CNT'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Magnitudes of the most negative inputs (2^29, 2^13) still fit unsigned.
  function automatic logic [W_DIN0-1:0] mag_din0(input logic [W_DIN0-1:0] v);
    return v[W_DIN0-1] ? -v : v;
  endfunction

  function automatic logic [W_DIN1-1:0] mag_din1(input logic [W_DIN1-1:0] v);
    return v[W_DIN1-1] ? -v : v;
  endfunction

endpackage

// File: rtl/alveo_hls4ml_sdiv_seq_30s_14s_16_if.sv
// Operand/result handshake bundle of the sequential signed divider.
interface alveo_hls4ml_sdiv_seq_30s_14s_16_if;
  import alveo_hls4ml_sdiv_seq_30s_14s_16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [W_DIN0-1:0] din0;
  logic [W_DIN1-1:0] din1;
  logic              out_valid;
  logic              out_ready;
  logic [W_DOUT-1:0] dout;
  logic [W_DIN1-1:0] rem;
  logic              ovf;
  logic              dz;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem, ovf, dz
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem, ovf, dz
  );

endinterface

// File: rtl/alveo_hls4ml_udiv_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module alveo_hls4ml_udiv_step
  import alveo_hls4ml_sdiv_seq_30s_14s_16_pkg::*;
(
  input  logic [W_DIN1-1:0] rem_i,
  input  logic [W_DIN1-1:0] dvs_i,
  input  logic              bit_i,
  output logic [W_DIN1-1:0] rem_o,
  output logic              q_o
);

  logic [W_DIN1:0]   shifted;
  logic [W_DIN1-1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, dvs_i});
  // When q_o is set the true difference is below dvs_i, so the low bits suffice.
  assign diff    = shifted[W_DIN1-1:0] - dvs_i;
  assign rem_o   = q_o ? diff : shifted[W_DIN1-1:0];

endmodule

// File: rtl/alveo_hls4ml_sdiv_seq_30s_14s_16.sv
// Fixed-latency iterative signed divider: 30s / 14s -> saturated 16s quotient
// plus 14s remainder whose sign follows the dividend.
module alveo_hls4ml_sdiv_seq_30s_14s_16
  import alveo_hls4ml_sdiv_seq_30s_14s_16_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 30,
  parameter int din1_WIDTH = 14,
  parameter int dout_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  input logic ce,
  alveo_hls4ml_sdiv_seq_30s_14s_16_if.slave io
);

  if (din0_WIDTH != W_DIN0 || din1_WIDTH != W_DIN1 || dout_WIDTH != W_DOUT || ID < 0)
  begin : g_bad_cfg
    $error("alveo_hls4ml_sdiv_seq_30s_14s_16: unsupported width parameters");
  end

  state_e            state_q;
  logic [W_CNT-1:0]  cnt_q;
  logic [W_DIN0-1:0] dvd_q;      // dividend bits shift out, quotient bits shift in
  logic [W_DIN1-1:0] dvs_q;
  logic [W_DIN1-1:0] prem_q;
  logic              quot_neg_q;
  logic              rem_neg_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [W_DOUT-1:0] dout_q;
  logic [W_DIN1-1:0] rem_q;
  logic              ovf_q;
  logic              dz_q;

  logic [W_DIN1-1:0] prem_d;
  logic              qbit_d;
  logic [W_DOUT-1:0] dout_d;
  logic [W_DIN1-1:0] rem_d;
  logic              ovf_d;
  logic              dz_d;

  alveo_hls4ml_udiv_step u_step (
    .rem_i (prem_q),
    .dvs_i (dvs_q),
    .bit_i (dvd_q[W_DIN0-1]),
    .rem_o (prem_d),
    .q_o   (qbit_d)
  );

  // Sign application and saturation, consumed only in FIX.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    dout_d = '0;
    rem_d  = '0;
    ovf_d  = 1'b0;
    dz_d   = 1'b0;
    if (dvs_q == '0) begin
      dz_d   = 1'b1;
      dout_d = rem_neg_q ? QMIN : QMAX;
    end else begin
      rem_d = rem_neg_q ? -prem_q : prem_q;
      if (!quot_neg_q && dvd_q > W_DIN0'(32767)) begin
        dout_d = QMAX;
        ovf_d  = 1'b1;
      end else if (quot_neg_q && dvd_q > W_DIN0'(32768)) begin
        dout_d = QMIN;
        ovf_d  = 1'b1;
      end else begin
        dout_d = quot_neg_q ? -dvd_q[W_DOUT-1:0] : dvd_q[W_DOUT-1:0];
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            quot_neg_q <= io.din0[W_DIN0-1] ^ io.din1[W_DIN1-1];
            rem_neg_q  <= io.din0[W_DIN0-1];
            dvd_q      <= mag_din0(io.din0);
            dvs_q      <= mag_din1(io.din1);
            prem_q     <= '0;
            cnt_q      <= CNT_LAST;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dvd_q  <= {dvd_q[W_DIN0-2:0], qbit_d};
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        FIX: begin
          dout_q      <= dout_d;
          rem_q       <= rem_d;
          ovf_q       <= ovf_d;
          dz_q        <= dz_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.dout      = dout_q;
  assign io.rem       = rem_q;
  assign io.ovf       = ovf_q;
  assign io.dz        = dz_q;

endmodule
